mem_arbiter_rr: RTL and testbench

Parametrised N-port arbiter between the split L1 caches (plus optional prefetch/DMA ports) and the single physical-memory port. Each port issues whole-line reads or writes; the block grants one requester at a time under round-robin or fixed priority. It registers the granted address, data and operation so the pmem side stays stable for the whole transaction. It then steers the response back to the granted port only.

---
 rtl/mem_arbiter_rr.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port line-request arbiter in front of a single physical-memory port.
// Round-robin or fixed-priority grant; the winning transaction is registered and held until pmem_resp.
module mem_arbiter_rr #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32,
   parameter int PRIO_MODE = 0,
   localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_read,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]        req_resp,
   output logic [LINE_W-1:0]           req_rdata,
   input  logic                        pmem_resp,
   input  logic [LINE_W-1:0]           pmem_rdata,
   output logic                        pmem_read,
   output logic                        pmem_write,
   output logic [ADDR_W-1:0]           pmem_address,
   output logic [LINE_W-1:0]           pmem_wdata,
   output logic [ID_W-1:0]             grant_id,
   output logic                        busy
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                busy_q, busy_d;

   logic [NUM_PORTS-1:0] active_s;
   logic [ID_W-1:0]      start_s;
   logic [ID_W-1:0]      cand_s;
   logic [ID_W-1:0]      win_idx_s;
   logic                 win_found_s;

   // Winner search: first active port in circular order from the start index.
   always_comb begin
      active_s    = req_read | req_write;
      start_s     = (PRIO_MODE == 1) ? {ID_W{1'b0}} : ptr_q;
      cand_s      = {ID_W{1'b0}};
      win_found_s = 1'b0;
      win_idx_s   = {ID_W{1'b0}};
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand_s = ID_W'((int'(start_s) + k) % NUM_PORTS);
         if (!win_found_s && active_s[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state logic plus the combinational response path back to the granted port.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      req_resp  = {NUM_PORTS{1'b0}};
      req_rdata = {LINE_W{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (win_found_s) begin
               state_d = S_BUSY;
               grant_d = win_idx_s;
               addr_d  = req_addr[win_idx_s*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[win_idx_s*LINE_W +: LINE_W];
               // A port raising both read and write is served as a write.
               wr_d    = req_write[win_idx_s];
               rd_d    = ~req_write[win_idx_s];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (pmem_resp) begin
               state_d            = S_IDLE;
               rd_d               = 1'b0;
               wr_d               = 1'b0;
               req_resp[grant_q]  = 1'b1;
               req_rdata          = pmem_rdata;
               if (PRIO_MODE == 1) begin
                  ptr_d = ptr_q;
               end else if (grant_q == ID_W'(NUM_PORTS - 1)) begin
                  ptr_d = {ID_W{1'b0}};
               end else begin
                  ptr_d = grant_q + ID_W'(1);
               end
            end else begin
               state_d = S_BUSY;
            end
         end
         default: begin
            state_d = S_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
      busy_d = (state_d == S_BUSY);
   end

   // State and transaction registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= {ID_W{1'b0}};
         grant_q <= {ID_W{1'b0}};
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {LINE_W{1'b0}};
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign grant_id     = grant_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance, each run through
// directed scenarios and random traffic against a transaction-level model checked every cycle.
module tb_mem_arbiter_rr;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int LW = 64;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input int mode, input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL m%0d %s act=%0h exp=%0h t=%0t", mode, name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar m = 0; m < 2; m++) begin : g_inst
      localparam int MODE = m;

      logic                 rst;
      logic [NP-1:0]        req_read, req_write, req_resp;
      logic [NP*AW-1:0]     req_addr;
      logic [NP*LW-1:0]     req_wdata;
      logic [LW-1:0]        req_rdata, pmem_rdata, pmem_wdata;
      logic                 pmem_resp, pmem_read, pmem_write, busy;
      logic [AW-1:0]        pmem_address;
      logic [1:0]           grant_id;
      logic [NP-1:0]        last_resp = '0;
      bit                   fin = 1'b0;

      // Model of the transaction in flight
      int                   m_busy = 0, m_gid = 0, m_ptr = 0;
      logic                 m_wr = 1'b0;
      logic [AW-1:0]        m_addr = '0;
      logic [LW-1:0]        m_wdata = '0;

      mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .PRIO_MODE(MODE)) dut (
         .clk(clk), .rst(rst),
         .req_read(req_read), .req_write(req_write),
         .req_addr(req_addr), .req_wdata(req_wdata),
         .req_resp(req_resp), .req_rdata(req_rdata),
         .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
         .pmem_read(pmem_read), .pmem_write(pmem_write),
         .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
         .grant_id(grant_id), .busy(busy)
      );

      // Model update at each clock edge
      always @(posedge clk) begin : mdl
         int idx;
         bit found;
         found = 1'b0;
         if (rst) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
         end else if (m_busy == 0) begin
            for (int k = 0; k < NP; k++) begin
               idx = (((MODE == 1) ? 0 : m_ptr) + k) % NP;
               if (!found && (req_read[idx] || req_write[idx])) begin
                  found   = 1'b1;
                  m_busy  = 1;
                  m_gid   = idx;
                  m_wr    = req_write[idx];
                  m_addr  = req_addr[idx*AW +: AW];
                  m_wdata = req_wdata[idx*LW +: LW];
               end
            end
         end else if (pmem_resp) begin
            m_busy = 0;
            if (MODE == 0) m_ptr = (m_gid + 1) % NP;
         end
      end

      // Every-cycle comparison of all outputs against the model
      always @(negedge clk) begin : cmp
         logic [NP-1:0] e_resp;
         logic [LW-1:0] e_rdata;
         e_resp  = (m_busy != 0 && pmem_resp) ? (4'b0001 << m_gid) : 4'b0000;
         e_rdata = (m_busy != 0 && pmem_resp) ? pmem_rdata : '0;
         check(MODE, "busy", busy, m_busy != 0);
         check(MODE, "pmem_read", pmem_read, m_busy != 0 && !m_wr);
         check(MODE, "pmem_write", pmem_write, m_busy != 0 && m_wr);
         check(MODE, "pmem_address", pmem_address, m_addr);
         check(MODE, "pmem_wdata", pmem_wdata, m_wdata);
         check(MODE, "grant_id", grant_id, m_gid[1:0]);
         check(MODE, "req_resp", req_resp, e_resp);
         check(MODE, "req_rdata", req_rdata, e_rdata);
         last_resp = req_resp;
      end

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      initial begin : stim
         int exp_g;
         logic [LW-1:0] pat;
         logic [LW-1:0] dead;
         pat  = 64'hA5A5_0F0F_1234_5678;
         dead = 64'hDEAD_BEEF_DEAD_BEEF;
         rst = 1'b1; req_read = 4'b1111; req_write = 4'b0000;
         req_addr = '0; req_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;

         // Reset held two cycles with every port requesting
         step(); step();
         @(negedge clk);
         check(MODE, "rst_busy", busy, 1'b0);
         check(MODE, "rst_read", pmem_read, 1'b0);
         check(MODE, "rst_addr", pmem_address, 32'h0);
         rst = 1'b0;
         step();
         pmem_resp = 1'b1; req_read = 4'b0000;
         @(negedge clk);
         check(MODE, "first_grant", grant_id, 2'd0);
         check(MODE, "first_resp", req_resp, 4'b0001);
         step();
         pmem_resp = 1'b0;

         // Single read from port 1, memory answers in the sixth busy cycle
         req_read[1] = 1'b1; req_addr[1*AW +: AW] = 32'h0000_1040;
         step();
         for (int j = 1; j <= 6; j++) begin
            if (j == 6) begin pmem_resp = 1'b1; pmem_rdata = pat; end
            @(negedge clk);
            check(MODE, "sr_read", pmem_read, 1'b1);
            check(MODE, "sr_addr", pmem_address, 32'h0000_1040);
            check(MODE, "sr_resp", req_resp, (j == 6) ? 4'b0010 : 4'b0000);
            if (j == 6) begin
               check(MODE, "sr_rdata", req_rdata, pat);
               req_read[1] = 1'b0;
            end
            step();
         end
         pmem_resp = 1'b0;
         @(negedge clk);
         check(MODE, "sr_idle_read", pmem_read, 1'b0);
         check(MODE, "sr_idle_resp", req_resp, 4'b0000);

         // Continuous requests with a one-cycle memory: grant order
         rst = 1'b1;
         step();
         rst = 1'b0; req_read = (MODE == 0) ? 4'b1111 : 4'b0101; pmem_resp = 1'b1;
         for (int k = 0; k < 8; k++) begin
            step();
            exp_g = (MODE == 0) ? (k % 4) : ((k < 4) ? 0 : 2);
            @(negedge clk);
            check(MODE, "order_grant", grant_id, exp_g[1:0]);
            check(MODE, "order_resp", req_resp, 4'b0001 << exp_g);
            if (MODE == 1 && k == 3) req_read[0] = 1'b0;
            step();
         end
         req_read = 4'b0000; pmem_resp = 1'b0;
         step();

         // Write from port 0 with requester inputs churning while busy
         req_write[0] = 1'b1; req_addr[0 +: AW] = 32'h0000_2000; req_wdata[0 +: LW] = dead;
         step();
         for (int j = 0; j < 4; j++) begin
            req_addr[0 +: AW] = $urandom; req_wdata[0 +: LW] = {$urandom, $urandom};
            req_read = 4'($urandom); req_write = 4'($urandom);
            @(negedge clk);
            check(MODE, "wr_strobe", pmem_write, 1'b1);
            check(MODE, "wr_addr", pmem_address, 32'h0000_2000);
            check(MODE, "wr_data", pmem_wdata, dead);
            check(MODE, "wr_noresp", req_resp, 4'b0000);
            step();
         end
         pmem_resp = 1'b1; req_read = 4'b0000; req_write = 4'b0000;
         @(negedge clk);
         check(MODE, "wr_resp", req_resp, 4'b0001);
         step();
         pmem_resp = 1'b0;
         @(negedge clk);
         check(MODE, "wr_hold_addr", pmem_address, 32'h0000_2000);
         check(MODE, "wr_hold_data", pmem_wdata, dead);
         check(MODE, "wr_done", pmem_write, 1'b0);

         // Reset while memory is stalled
         req_read[3] = 1'b1;
         step();
         @(negedge clk);
         check(MODE, "mr_grant", grant_id, 2'd3);
         rst = 1'b1;
         step();
         rst = 1'b0; req_read = 4'b1111;
         @(negedge clk);
         check(MODE, "mr_read", pmem_read, 1'b0);
         check(MODE, "mr_busy", busy, 1'b0);
         check(MODE, "mr_resp", req_resp, 4'b0000);
         step();
         pmem_resp = 1'b1; req_read = 4'b0000;
         @(negedge clk);
         check(MODE, "mr_next_grant", grant_id, 2'd0);
         step();

         // Random traffic with a well-behaved requester per port
         for (int c = 0; c < 1500; c++) begin
            int op;
            rst = ($urandom_range(0, 199) == 0);
            pmem_resp = ($urandom_range(0, 2) == 0);
            pmem_rdata = {$urandom, $urandom};
            for (int i = 0; i < NP; i++) begin
               if (last_resp[i]) begin
                  req_read[i] = 1'b0; req_write[i] = 1'b0;
               end else if (!(req_read[i] || req_write[i]) && $urandom_range(0, 3) == 0) begin
                  op = $urandom_range(0, 4);
                  req_read[i]  = (op < 2) || (op == 4);
                  req_write[i] = (op >= 2);
                  req_addr[i*AW +: AW]  = $urandom;
                  req_wdata[i*LW +: LW] = {$urandom, $urandom};
               end
            end
            step();
         end
         fin = 1'b1;
      end
   end

   initial begin
      for (int c = 0; c < 20000; c++) begin
         if (g_inst[0].fin && g_inst[1].fin) break;
         @(posedge clk);
      end
      checks++;
      if (!(g_inst[0].fin && g_inst[1].fin)) begin
         errors++;
         $display("FAIL timeout fin=%0d%0d exp=11", g_inst[0].fin, g_inst[1].fin);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
